sram22_bist_march: RTL and testbench

- March C- built-in self-test initiator for sram22 single-port macros; it is the requester side of the macro port (`we`, `wmask`, `addr`, `din` out; `dout` in).
- It sits between the test controller (start/status) and one SRAM instance, muxed onto the macro port by the integrator while `busy`=1.
- It walks every word through six march elements, compares read data one cycle after each read, and reports pass/fail plus the first failing location.

---
 rtl/sram22_bist_march_pkg.sv | 35 +++
 rtl/sram22_bist_march_if.sv | 17 +
 rtl/sram22_bist_addr_gen.sv | 30 +++
 rtl/sram22_bist_march.sv | 170 +++++++++++++++++
 tb/tb_sram22_bist_march.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sram22_bist_march_pkg.sv
// Shared types and the March C- element table for the sram22 BIST initiator.
package sram22_bist_pkg;

    typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NUM_ELEMS = 6;

    typedef struct packed {
        logic       down;
        logic [1:0] num_ops;
        op_t        op0;
        op_t        op1;
    } elem_t;

    // March C-: {w0} up, {r0,w1} up, {r1,w0} up, {r0,w1} down, {r1,w0} down, {r0} up
    localparam elem_t MARCH_TABLE [NUM_ELEMS] = '{
        '{1'b0, 2'd1, OP_W0, OP_W0},
        '{1'b0, 2'd2, OP_R0, OP_W1},
        '{1'b0, 2'd2, OP_R1, OP_W0},
        '{1'b1, 2'd2, OP_R0, OP_W1},
        '{1'b1, 2'd2, OP_R1, OP_W0},
        '{1'b0, 2'd1, OP_R0, OP_R0}
    };

    function automatic logic op_is_read(input op_t op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    function automatic logic op_is_one(input op_t op);
        return (op == OP_R1) || (op == OP_W1);
    endfunction

endpackage

// File: rtl/sram22_bist_march_if.sv
// Single-port sram22 macro port; the BIST is the master, the macro the slave.
interface sram22_bist_march_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = 4
);

    logic                   we;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic [DATA_WIDTH-1:0]  dout;

    modport master (output we, wmask, addr, din, input dout);
    modport slave  (input we, wmask, addr, din, output dout);

endinterface

// File: rtl/sram22_bist_addr_gen.sv
// Up/down word address counter; load picks the start address for the direction.
module sram22_bist_addr_gen #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic down;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            down <= load_down;
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram22_bist_march.sv
// March C- BIST initiator: drives one sram22 macro through six march elements
// and records pass/fail plus the first failing location.
module sram22_bist_march
    import sram22_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    WMASK_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND  = '0
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [15:0]           fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    sram22_bist_march_if.master   sram
);

    state_t state, state_next;
    logic draining, draining_next;
    logic [2:0] elem, elem_next;
    logic op_idx, op_next;

    logic ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    elem_t cur;
    op_t   cur_op;
    logic  active;
    logic  start_accept;

    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_exp;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic [2:0]            pipe_elem;

    assign cur          = MARCH_TABLE[elem];
    assign cur_op       = op_idx ? cur.op1 : cur.op0;
    assign active       = (state == RUN) && !draining;
    assign start_accept = start && (state != RUN);

    sram22_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rstb      (rstb),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            draining <= 1'b0;
            elem     <= '0;
            op_idx   <= 1'b0;
        end else begin
            state    <= state_next;
            draining <= draining_next;
            elem     <= elem_next;
            op_idx   <= op_next;
        end
    end

    // After the final op is issued, one extra RUN cycle lets its compare resolve.
    always_comb begin
        state_next    = state;
        draining_next = draining;
        elem_next     = elem;
        op_next       = op_idx;
        ag_load       = 1'b0;
        ag_load_down  = 1'b0;
        ag_step       = 1'b0;

        busy       = (state == RUN);
        done       = (state == DONE);
        sram.we    = 1'b0;
        sram.wmask = '0;
        sram.addr  = '0;
        sram.din   = '0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = RUN;
                    draining_next = 1'b0;
                    elem_next     = '0;
                    op_next       = 1'b0;
                    ag_load       = 1'b1;
                    ag_load_down  = MARCH_TABLE[0].down;
                end
            end
            RUN: begin
                if (draining) begin
                    state_next    = DONE;
                    draining_next = 1'b0;
                end else if ((cur.num_ops == 2'd2) && !op_idx) begin
                    op_next = 1'b1;
                end else begin
                    op_next = 1'b0;
                    if (!ag_last) begin
                        ag_step = 1'b1;
                    end else if (elem == 3'(NUM_ELEMS - 1)) begin
                        draining_next = 1'b1;
                    end else begin
                        elem_next    = elem + 3'd1;
                        ag_load      = 1'b1;
                        ag_load_down = MARCH_TABLE[elem + 3'd1].down;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (active) begin
            sram.addr = ag_addr;
            if (!op_is_read(cur_op)) begin
                sram.we    = 1'b1;
                sram.wmask = {WMASK_WIDTH{1'b1}};
                sram.din   = op_is_one(cur_op) ? ~BACKGROUND : BACKGROUND;
            end
        end
    end

    // Read data arrives one cycle after the macro samples the read, so the
    // expectation rides a one-stage pipeline alongside it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pipe_valid <= 1'b0;
            pipe_exp   <= '0;
            pipe_addr  <= '0;
            pipe_elem  <= '0;
            fail       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else begin
            pipe_valid <= active && op_is_read(cur_op);
            pipe_exp   <= op_is_one(cur_op) ? ~BACKGROUND : BACKGROUND;
            pipe_addr  <= ag_addr;
            pipe_elem  <= elem;

            if (start_accept) begin
                fail       <= 1'b0;
                fail_count <= '0;
                fail_addr  <= '0;
                fail_elem  <= '0;
                fail_data  <= '0;
            end else if (pipe_valid && (sram.dout != pipe_exp)) begin
                fail <= 1'b1;
                if (fail_count != 16'hFFFF) begin
                    fail_count <= fail_count + 16'd1;
                end
                if (!fail) begin
                    fail_addr <= pipe_addr;
                    fail_elem <= pipe_elem;
                    fail_data <= sram.dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram22_bist_march.sv
// Bench for sram22_bist_march: two BIST instances (background 0 and 5555_5555)
// each driving a behavioural macro with injectable stuck-at faults.
module tb_sram22_bist_march;

    localparam int DW         = 32;
    localparam int AW         = 9;
    localparam int MW         = 4;
    localparam int DEPTH      = 1 << AW;
    localparam int RUN_CYCLES = 10 * DEPTH + 1;
    localparam logic [DW-1:0] BG0 = 32'h0000_0000;
    localparam logic [DW-1:0] BG1 = 32'h5555_5555;

    typedef struct {
        int              fault;
        int              poke;
        logic            exp_fail;
        logic [15:0]     exp_count;
        logic [AW-1:0]   exp_addr;
        logic [2:0]      exp_elem;
        logic [DW-1:0]   exp_data0;
        logic [DW-1:0]   exp_data1;
    } run_t;

    logic clk = 1'b0;
    logic rstb;
    logic start;

    logic          busy0, done0, fail0, busy1, done1, fail1;
    logic [15:0]   count0, count1;
    logic [AW-1:0] faddr0, faddr1;
    logic [2:0]    felem0, felem1;
    logic [DW-1:0] fdata0, fdata1;

    int checks = 0;
    int errors = 0;
    int fault_kind = 0;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    run_t runs [3];
    run_t clean_run;

    sram22_bist_march_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus0 ();
    sram22_bist_march_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus1 ();

    sram22_bist_march #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .BACKGROUND(BG0)) dut0 (
        .clk(clk), .rstb(rstb), .start(start), .busy(busy0), .done(done0), .fail(fail0),
        .fail_count(count0), .fail_addr(faddr0), .fail_elem(felem0), .fail_data(fdata0),
        .sram(bus0)
    );

    sram22_bist_march #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .BACKGROUND(BG1)) dut1 (
        .clk(clk), .rstb(rstb), .start(start), .busy(busy1), .done(done1), .fail(fail1),
        .fail_count(count1), .fail_addr(faddr1), .fail_elem(felem1), .fail_data(fdata1),
        .sram(bus1)
    );

    always #5 clk = ~clk;

    // Fault 1: bit 3 stuck at 1 at 0x0A5. Fault 2: bit 31 stuck at 0 at 0 and 511.
    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (fault_kind == 1 && a == 9'h0A5) r[3] = 1'b1;
        if (fault_kind == 2 && (a == 9'h000 || a == 9'h1FF)) r[31] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < MW; b++) begin
            if (bus0.we && bus0.wmask[b]) mem0[bus0.addr][8*b +: 8] <= bus0.din[8*b +: 8];
            if (bus1.we && bus1.wmask[b]) mem1[bus1.addr][8*b +: 8] <= bus1.din[8*b +: 8];
        end
        bus0.dout <= faulty(mem0[bus0.addr], bus0.addr);
        bus1.dout <= faulty(mem1[bus1.addr], bus1.addr);
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One full run: start pulse, optional ignored start mid-run, wait for done, check status.
    task automatic apply_stimulus(input run_t r, input string tag);
        int cyc;
        int we_cnt;
        bit seen;
        fault_kind = r.fault;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_output({tag, " busy_at_start"},  64'(busy0), 64'd1);
        check_output({tag, " done_cleared"},   64'(done0), 64'd0);
        check_output({tag, " fail_cleared"},   64'(fail0), 64'd0);
        check_output({tag, " count_cleared"},  64'(count0), 64'd0);
        check_output({tag, " faddr_cleared"},  64'(faddr0), 64'd0);
        check_output({tag, " op0_we"},         64'(bus0.we), 64'd1);
        check_output({tag, " op0_wmask"},      64'(bus0.wmask), 64'hF);
        check_output({tag, " op0_addr"},       64'(bus0.addr), 64'd0);
        check_output({tag, " op0_din_bg0"},    64'(bus0.din), 64'(BG0));
        check_output({tag, " op0_din_bg1"},    64'(bus1.din), 64'(BG1));
        cyc    = 0;
        we_cnt = bus0.we ? 1 : 0;
        seen   = 1'b0;
        while (!seen && cyc < RUN_CYCLES + 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (r.poke != 0) && (cyc == r.poke - 1);
            if (bus0.we) we_cnt++;
            if (done0) seen = 1'b1;
        end
        start = 1'b0;
        check_output({tag, " done_cycle"},  64'(cyc), 64'(RUN_CYCLES));
        check_output({tag, " busy_end"},    64'(busy0), 64'd0);
        check_output({tag, " done1"},       64'(done1), 64'd1);
        check_output({tag, " busy1_end"},   64'(busy1), 64'd0);
        check_output({tag, " write_ops"},   64'(we_cnt), 64'(5 * DEPTH));
        check_output({tag, " idle_we"},     64'(bus0.we), 64'd0);
        check_output({tag, " idle_addr"},   64'(bus0.addr), 64'd0);
        check_output({tag, " fail0"},       64'(fail0), 64'(r.exp_fail));
        check_output({tag, " count0"},      64'(count0), 64'(r.exp_count));
        check_output({tag, " faddr0"},      64'(faddr0), 64'(r.exp_addr));
        check_output({tag, " felem0"},      64'(felem0), 64'(r.exp_elem));
        check_output({tag, " fdata0"},      64'(fdata0), 64'(r.exp_data0));
        check_output({tag, " fail1"},       64'(fail1), 64'(r.exp_fail));
        check_output({tag, " count1"},      64'(count1), 64'(r.exp_count));
        check_output({tag, " faddr1"},      64'(faddr1), 64'(r.exp_addr));
        check_output({tag, " felem1"},      64'(felem1), 64'(r.exp_elem));
        check_output({tag, " fdata1"},      64'(fdata1), 64'(r.exp_data1));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " busy"},   64'(busy0), 64'd0);
        check_output({tag, " done"},   64'(done0), 64'd0);
        check_output({tag, " fail"},   64'(fail0), 64'd0);
        check_output({tag, " count"},  64'(count0), 64'd0);
        check_output({tag, " faddr"},  64'(faddr0), 64'd0);
        check_output({tag, " felem"},  64'(felem0), 64'd0);
        check_output({tag, " fdata"},  64'(fdata0), 64'd0);
        check_output({tag, " we"},     64'(bus0.we), 64'd0);
        check_output({tag, " wmask"},  64'(bus0.wmask), 64'd0);
        check_output({tag, " addr"},   64'(bus0.addr), 64'd0);
        check_output({tag, " din"},    64'(bus0.din), 64'd0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        runs[0]   = '{0, 100, 1'b0, 16'd0, 9'h000, 3'd0, 32'h0000_0000, 32'h0000_0000};
        runs[1]   = '{1, 0,   1'b1, 16'd3, 9'h0A5, 3'd1, 32'h0000_0008, 32'h5555_555D};
        runs[2]   = '{2, 0,   1'b1, 16'd4, 9'h000, 3'd2, 32'h7FFF_FFFF, 32'h2AAA_AAAA};
        clean_run = '{0, 0,   1'b0, 16'd0, 9'h000, 3'd0, 32'h0000_0000, 32'h0000_0000};

        rstb  = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rstb = 1'b1;

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(runs[i], $sformatf("run%0d", i));
        end

        // Reset 3000 cycles into a faulty run: status must vanish immediately.
        fault_kind = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        check_output("midrun fail_before_reset", 64'(fail0), 64'd1);
        check_output("midrun busy_before_reset", 64'(busy0), 64'd1);
        rstb = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        apply_stimulus(clean_run, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
